tinker_cycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the Tinker core. Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB.

---
 rtl/tinker_pkg.sv | 40 ++++
 rtl/tinker_op_classify.sv | 35 +++
 rtl/tinker_cycle_ctrl.sv | 170 +++++++++++++++++
 tb/tb_tinker_cycle_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tinker_pkg.sv
// tinker_pkg: opcode constants, sequencer state and op-class enums
// shared by the Tinker multi-cycle control slice.
package tinker_pkg;

  localparam int unsigned OP_ALU_LO  = 0;
  localparam int unsigned OP_ALU_HI  = 7;
  localparam int unsigned OP_BR_LO   = 8;
  localparam int unsigned OP_BR_HI   = 11;
  localparam int unsigned OP_CALL    = 12;
  localparam int unsigned OP_RET     = 13;
  localparam int unsigned OP_BR_X    = 14;
  localparam int unsigned OP_HALT    = 15;
  localparam int unsigned OP_LOAD    = 16;
  localparam int unsigned OP_ALU_A   = 17;
  localparam int unsigned OP_ALU_B   = 18;
  localparam int unsigned OP_STORE   = 19;
  localparam int unsigned OP_ALU2_LO = 20;
  localparam int unsigned OP_ALU2_HI = 29;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    OC_ALU,
    OC_LOAD,
    OC_STORE,
    OC_CALL,
    OC_RET,
    OC_BRANCH,
    OC_HALT,
    OC_ILLEGAL
  } op_class_e;

endpackage

// File: rtl/tinker_op_classify.sv
// tinker_op_classify: combinational opcode -> op-class map.
// Ports: op (OP_W opcode) in, op_class (op_class_e) out.
module tinker_op_classify
  import tinker_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  logic [OP_W-1:0] op,
  output op_class_e       op_class
);

  logic [31:0] v;

  always_comb begin
    v = 32'(op);
    op_class = OC_ILLEGAL;
    unique case (1'b1)
      (v <= OP_ALU_HI),
      (v == OP_ALU_A),
      (v == OP_ALU_B),
      (v >= OP_ALU2_LO && v <= OP_ALU2_HI):
        op_class = OC_ALU;
      (v == OP_LOAD):  op_class = OC_LOAD;
      (v == OP_STORE): op_class = OC_STORE;
      (v == OP_CALL):  op_class = OC_CALL;
      (v == OP_RET):   op_class = OC_RET;
      (v >= OP_BR_LO && v <= OP_BR_HI),
      (v == OP_BR_X):
        op_class = OC_BRANCH;
      (v == OP_HALT):  op_class = OC_HALT;
      default:         op_class = OC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/tinker_cycle_ctrl.sv
// tinker_cycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with memory
// timeout; clk, reset (async, active-high), opcode, mem_rdy, alu_done in;
// mem_req/sel/we, ir_load, alu_start, reg_we, wb_sel, pc_we, illegal,
// halted, bus_err, cyc_cnt, ret_cnt out. Counters built only when
// TINKER_CTRL_PERF_EN is defined, otherwise tied to 0.
module tinker_cycle_ctrl
  import tinker_pkg::*;
#(
  parameter int OP_W        = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  opcode,
  input  logic             mem_rdy,
  input  logic             alu_done,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             mem_we,
  output logic             ir_load,
  output logic             alu_start,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             pc_we,
  output logic             illegal,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  localparam int WT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e          state;
  op_class_e       cls;
  logic [OP_W-1:0] op_q;
  logic [OP_W-1:0] cls_op;
  logic [WT_W-1:0] wait_cnt;
  logic            alu_wait;
  logic            bus_err_q;
  logic            in_mem;
  logic            tmo;
  logic            st_mem;

  // DECODE classifies the live opcode; later states use the captured one
  assign cls_op = (state == S_DECODE) ? opcode : op_q;

  tinker_op_classify #(.OP_W(OP_W)) u_cls (
    .op       (cls_op),
    .op_class (cls)
  );

  assign in_mem = (state == S_FETCH) || (state == S_MEM);
  assign tmo = (MEM_TIMEOUT != 0) && in_mem && !mem_rdy &&
               (wait_cnt == WT_W'(MEM_TIMEOUT - 1));
  assign st_mem = (cls == OC_STORE) || (cls == OC_CALL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      op_q      <= '0;
      wait_cnt  <= '0;
      alu_wait  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      wait_cnt <= (in_mem && !mem_rdy && !tmo) ? wait_cnt + 1'b1 : '0;
      alu_wait <= (state == S_EXEC) && (cls == OC_ALU) && !alu_done;
      unique case (state)
        S_FETCH: begin
          if (mem_rdy) begin
            state <= S_DECODE;
          end else if (tmo) begin
            state     <= S_HALT;
            bus_err_q <= 1'b1;
          end
        end
        S_DECODE: begin
          op_q  <= opcode;
          state <= (cls == OC_HALT) ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          case (cls)
            OC_ALU:  if (alu_done) state <= S_WB;
            OC_LOAD,
            OC_STORE,
            OC_CALL,
            OC_RET:  state <= S_MEM;
            default: state <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (mem_rdy) begin
            state <= (cls == OC_LOAD) ? S_WB : S_FETCH;
          end else if (tmo) begin
            state     <= S_HALT;
            bus_err_q <= 1'b1;
          end
        end
        S_WB:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_sel   = 1'b0;
    mem_we    = 1'b0;
    ir_load   = 1'b0;
    alu_start = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    pc_we     = 1'b0;
    illegal   = 1'b0;
    halted    = 1'b0;
    if (!reset) begin
      unique case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_load = mem_rdy;
        end
        S_DECODE: ;
        S_EXEC: begin
          alu_start = (cls == OC_ALU) && !alu_wait;
          pc_we     = (cls == OC_BRANCH) || (cls == OC_ILLEGAL);
          illegal   = (cls == OC_ILLEGAL);
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_sel = 1'b1;
          mem_we  = st_mem;
          pc_we   = mem_rdy && (cls != OC_LOAD);
        end
        S_WB: begin
          reg_we = 1'b1;
          wb_sel = (cls == OC_LOAD);
          pc_we  = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus_err = bus_err_q;

`ifdef TINKER_CTRL_PERF_EN
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] ret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (!halted) cyc_q <= cyc_q + 1'b1;
      if (pc_we)   ret_q <= ret_q + 1'b1;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`else
  assign cyc_cnt = '0;
  assign ret_cnt = '0;
`endif

endmodule

// File: tb/tb_tinker_cycle_ctrl.sv
// tb_tinker_cycle_ctrl: directed and random instruction streams against
// a per-instruction cycle-trace model of the sequencer.
module tb_tinker_cycle_ctrl;

  localparam int TMO = 4;

`ifdef TINKER_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic req, sel, we, irl, alus, rwe, wbs, pcwe, ill, hlt, berr;
  } ov_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  opcode = '0;
  logic        mem_rdy = 1'b0;
  logic        alu_done = 1'b0;
  logic        mem_req, mem_sel, mem_we, ir_load, alu_start;
  logic        reg_we, wb_sel, pc_we, illegal, halted, bus_err;
  logic [31:0] cyc_cnt, ret_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_cyc = '0;
  logic [31:0] m_ret = '0;

  tinker_cycle_ctrl #(
    .OP_W(5), .MEM_TIMEOUT(TMO), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .mem_rdy(mem_rdy), .alu_done(alu_done),
    .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we),
    .ir_load(ir_load), .alu_start(alu_start), .reg_we(reg_we),
    .wb_sel(wb_sel), .pc_we(pc_we), .illegal(illegal),
    .halted(halted), .bus_err(bus_err),
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
  );

  always #5 clk = ~clk;

  function automatic ov_t outs();
    return {mem_req, mem_sel, mem_we, ir_load, alu_start, reg_we,
            wb_sel, pc_we, illegal, halted, bus_err};
  endfunction

  // 0 alu 1 load 2 store 3 call 4 ret 5 branch 6 halt 7 undefined
  function automatic int klass(input logic [4:0] op);
    if (op inside {[5'd0:5'd7], 5'd17, 5'd18, [5'd20:5'd29]}) return 0;
    if (op == 5'd16) return 1;
    if (op == 5'd19) return 2;
    if (op == 5'd12) return 3;
    if (op == 5'd13) return 4;
    if (op inside {[5'd8:5'd11], 5'd14}) return 5;
    if (op == 5'd15) return 6;
    return 7;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model
  task automatic step(input logic rdy, input logic done, input ov_t e);
    mem_rdy  = rdy;
    alu_done = done;
    @(negedge clk);
    chk($sformatf("outs op=%0d", opcode), 64'(outs()), 64'(e));
    chk("cyc_cnt", 64'(cyc_cnt), PERF ? 64'(m_cyc) : 64'd0);
    chk("ret_cnt", 64'(ret_cnt), PERF ? 64'(m_ret) : 64'd0);
    @(posedge clk);
    #1;
    if (!e.hlt) m_cyc = m_cyc + 1;
    if (e.pcwe) m_ret = m_ret + 1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    mem_rdy  = 1'b1;
    alu_done = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_outs", 64'(outs()), 64'd0);
    chk("rst_cnt", {cyc_cnt, ret_cnt}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_cyc = '0;
    m_ret = '0;
  endtask

  // Request phase of w wait cycles; w >= TMO models a bus timeout
  task automatic mem_phase(input logic sel, input logic we, input int w,
                           input ov_t fin, output bit ok);
    ov_t e;
    for (int i = 0; i < w && i < TMO; i++) begin
      e = '0; e.req = 1'b1; e.sel = sel; e.we = we;
      step(1'b0, 1'($urandom), e);
    end
    if (w >= TMO) begin
      e = '0; e.hlt = 1'b1; e.berr = 1'b1;
      repeat (5) step(1'($urandom), 1'($urandom), e);
      ok = 1'b0;
    end else begin
      e = fin; e.req = 1'b1; e.sel = sel; e.we = we;
      step(1'b1, 1'($urandom), e);
      ok = 1'b1;
    end
  endtask

  task automatic run_instr(input logic [4:0] op, input int fw,
                           input int mw, input int aw, output bit ok);
    ov_t e;
    int  k;
    k = klass(op);
    opcode = 5'($urandom);
    e = '0; e.irl = 1'b1;
    mem_phase(1'b0, 1'b0, fw, e, ok);
    if (!ok) return;
    opcode = op;
    step(1'($urandom), 1'($urandom), '0);
    opcode = 5'($urandom);
    ok = 1'b1;
    case (k)
      0: begin
        for (int i = 0; i <= aw; i++) begin
          e = '0; e.alus = (i == 0);
          step(1'($urandom), (i == aw), e);
        end
        e = '0; e.rwe = 1'b1; e.pcwe = 1'b1;
        step(1'($urandom), 1'($urandom), e);
      end
      1: begin
        step(1'($urandom), 1'($urandom), '0);
        mem_phase(1'b1, 1'b0, mw, '0, ok);
        if (!ok) return;
        e = '0; e.rwe = 1'b1; e.wbs = 1'b1; e.pcwe = 1'b1;
        step(1'($urandom), 1'($urandom), e);
      end
      2, 3, 4: begin
        step(1'($urandom), 1'($urandom), '0);
        e = '0; e.pcwe = 1'b1;
        mem_phase(1'b1, (k != 4), mw, e, ok);
      end
      5: begin
        e = '0; e.pcwe = 1'b1;
        step(1'($urandom), 1'($urandom), e);
      end
      6: begin
        e = '0; e.hlt = 1'b1;
        repeat (4) step(1'($urandom), 1'($urandom), e);
        ok = 1'b0;
      end
      default: begin
        e = '0; e.pcwe = 1'b1; e.ill = 1'b1;
        step(1'($urandom), 1'($urandom), e);
      end
    endcase
  endtask

  initial begin
    bit  ok;
    ov_t e;
    do_reset();
    run_instr(5'b11001, 0, 0, 0, ok);
    run_instr(5'b10000, 0, 3, 0, ok);
    run_instr(5'b01100, 1, 2, 0, ok);
    run_instr(5'b10011, 3, 0, 0, ok);
    run_instr(5'b01101, 0, 1, 0, ok);
    run_instr(5'b01000, 2, 0, 0, ok);
    run_instr(5'b00011, 0, 0, 3, ok);
    run_instr(5'b11111, 0, 0, 0, ok);
    run_instr(5'b11110, 1, 0, 0, ok);
    run_instr(5'b01111, 0, 0, 0, ok);
    do_reset();
    mem_phase(1'b0, 1'b0, 99, '0, ok);
    do_reset();
    run_instr(5'b10000, 0, TMO, 0, ok);
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int mw;
      mw = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 3);
      run_instr(5'($urandom), $urandom_range(0, 3), mw,
                $urandom_range(0, 3), ok);
      if (!ok) do_reset();
    end
    do_reset();
    run_instr(5'b00001, 0, 0, 0, ok);
    opcode = 5'b10011;
    e = '0; e.irl = 1'b1; e.req = 1'b1;
    step(1'b1, 1'b0, e);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    mem_rdy = 1'b0;
    @(negedge clk);
    chk("mid_we", 64'(mem_we), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_we_drop", 64'(mem_we), 64'd0);
    chk("rst_mid_outs", 64'(outs()), 64'd0);
    chk("rst_mid_cnt", {cyc_cnt, ret_cnt}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_cyc = '0;
    m_ret = '0;
    run_instr(5'b01010, 0, 0, 0, ok);
    run_instr(5'b11001, 0, 0, 0, ok);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
